// File: rtl/addr_seq_pkg.sv
// -----------------------------------------------------------------------------
// addr_seq_pkg
//   Shared types, default widths and the address-advance function used by the
//   addr_sequencer block.
//
//   Contents:
//     seq_state_e  - FSM state encoding {ST_IDLE, ST_BURST}
//     *_DEF        - default parameter values for the top level
//     MAXW         - working width of next_addr (AW must be below MAXW)
//     next_addr()  - modular add of a signed step with optional ring window,
//                    returns {wrapped, addr}
// -----------------------------------------------------------------------------
package addr_seq_pkg;

  localparam int unsigned AW_DEF   = 16;
  localparam int unsigned NSRC_DEF = 2;
  localparam int unsigned SW_DEF   = 8;
  localparam int unsigned LW_DEF   = 8;

  // next_addr works on a fixed 32-bit datapath so one function serves every
  // AW. Callers zero-extend the address and bounds and sign-extend the step.
  localparam int unsigned MAXW = 32;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } seq_state_e;

  // Returns {wrapped, addr}. Only the low aw bits of addr are meaningful;
  // bits above aw are always zero.
  //
  // Overflow detection: a < 2^aw and |s| is small, so a+s in MAXW bits only
  // has bits set above aw when the sum carried past 2^aw (positive step) or
  // borrowed below 0 (negative step, upper bits become all ones).
  function automatic logic [MAXW:0] next_addr(
    input logic [MAXW-1:0] a,
    input logic [MAXW-1:0] s,
    input logic            ring_en,
    input logic [MAXW-1:0] lo,
    input logic [MAXW-1:0] hi,
    input int unsigned     aw
  );
    logic [MAXW-1:0] mask;
    logic [MAXW-1:0] sum;
    logic [MAXW-1:0] res;
    logic            wrap;
    mask = (MAXW'(1) << aw) - MAXW'(1);
    sum  = a + s;
    wrap = |(sum & ~mask);
    res  = sum & mask;
    if (ring_en) begin
      // Fold the overshoot back into the window from the opposite bound.
      if (res > hi) begin
        res  = (lo + (res - hi - MAXW'(1))) & mask;
        wrap = 1'b1;
      end else if (res < lo) begin
        res  = (hi - (lo - res - MAXW'(1))) & mask;
        wrap = 1'b1;
      end
    end
    return {wrap, res};
  endfunction

endpackage

// File: rtl/addr_src_mux.sv
// -----------------------------------------------------------------------------
// addr_src_mux
//   Combinational priority select over NSRC parallel load sources. When several
//   strobes are asserted the highest-index source wins.
//
//   Ports:
//     i_load_en   [NSRC-1:0]    per-source load strobes
//     i_load_data [NSRC*AW-1:0] source i at bits [i*AW +: AW]
//     o_any                     at least one strobe asserted
//     o_data      [AW-1:0]      data of the winning source (0 if none)
// -----------------------------------------------------------------------------
module addr_src_mux
  import addr_seq_pkg::*;
#(
  parameter int unsigned NSRC = NSRC_DEF,
  parameter int unsigned AW   = AW_DEF
) (
  input  logic [NSRC-1:0]    i_load_en,
  input  logic [NSRC*AW-1:0] i_load_data,
  output logic               o_any,
  output logic [AW-1:0]      o_data
);

  // Ascending scan: a later (higher-index) hit overwrites an earlier one.
  always_comb begin
    o_any  = 1'b0;
    o_data = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (i_load_en[i]) begin
        o_any  = 1'b1;
        o_data = i_load_data[i*AW +: AW];
      end
    end
  end

endmodule

// File: rtl/addr_sequencer.sv
// -----------------------------------------------------------------------------
// addr_sequencer
//   Address register with clear / multi-source load / signed step and an
//   optional ring window, plus a handshaked burst generator that emits
//   max(burst_len,1) addresses at a fixed signed stride.
//
//   Ports:
//     i_clk, i_rst_n            clock, synchronous active-low reset
//     i_clr                     addr to 0, aborts a burst (no done)
//     i_load_en/i_load_data     NSRC load sources, highest index wins
//     i_step_en/i_step          signed step add (IDLE only)
//     i_ring_en/lo/hi           ring window applied to step and stride adds
//     i_burst_start/base/len/stride  burst request (IDLE only)
//     i_addr_ready              consumer accepts o_addr
//     o_addr                    registered current address
//     o_addr_valid, o_busy      high while in BURST
//     o_done                    one-cycle pulse after the last beat accepted
//     o_wrapped                 one-cycle pulse on ring crossing or overflow
//     o_dbg_state               current FSM state
//
//   Handshake: a beat transfers on a rising edge where o_addr_valid and
//   i_addr_ready are both high. While o_addr_valid is high and the beat has
//   not transferred, o_addr is held stable; the consumer may drop or raise
//   i_addr_ready freely.
// -----------------------------------------------------------------------------
module addr_sequencer
  import addr_seq_pkg::*;
#(
  parameter int unsigned AW   = AW_DEF,
  parameter int unsigned NSRC = NSRC_DEF,
  parameter int unsigned SW   = SW_DEF,
  parameter int unsigned LW   = LW_DEF
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_clr,
  input  logic [NSRC-1:0]    i_load_en,
  input  logic [NSRC*AW-1:0] i_load_data,
  input  logic               i_step_en,
  input  logic [SW-1:0]      i_step,
  input  logic               i_ring_en,
  input  logic [AW-1:0]      i_ring_lo,
  input  logic [AW-1:0]      i_ring_hi,
  input  logic               i_burst_start,
  input  logic [AW-1:0]      i_burst_base,
  input  logic [LW-1:0]      i_burst_len,
  input  logic [SW-1:0]      i_burst_stride,
  input  logic               i_addr_ready,
  output logic [AW-1:0]      o_addr,
  output logic               o_addr_valid,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_wrapped,
  output seq_state_e         o_dbg_state
);

  seq_state_e    r_state;
  logic [AW-1:0] r_addr;
  logic [LW-1:0] r_beats;
  logic          r_done;
  logic          r_wrapped;

  // Load source selection
  logic          w_load_any;
  logic [AW-1:0] w_load_data;

  addr_src_mux #(
    .NSRC (NSRC),
    .AW   (AW)
  ) u_src_mux (
    .i_load_en   (i_load_en),
    .i_load_data (i_load_data),
    .o_any       (w_load_any),
    .o_data      (w_load_data)
  );

  // Operands widened to the next_addr working width
  logic [MAXW-1:0] w_addr_ext;
  logic [MAXW-1:0] w_step_ext;
  logic [MAXW-1:0] w_stride_ext;
  logic [MAXW-1:0] w_lo_ext;
  logic [MAXW-1:0] w_hi_ext;

  assign w_addr_ext   = MAXW'(r_addr);
  assign w_step_ext   = {{(MAXW-SW){i_step[SW-1]}}, i_step};
  assign w_stride_ext = {{(MAXW-SW){i_burst_stride[SW-1]}}, i_burst_stride};
  assign w_lo_ext     = MAXW'(i_ring_lo);
  assign w_hi_ext     = MAXW'(i_ring_hi);

  // Candidate next addresses for IDLE stepping and BURST striding
  logic [MAXW:0]   w_step_full;
  logic [MAXW:0]   w_stride_full;
  logic [AW-1:0]   w_step_addr;
  logic [AW-1:0]   w_stride_addr;
  logic            w_step_wrap;
  logic            w_stride_wrap;

  assign w_step_full   = next_addr(w_addr_ext, w_step_ext, i_ring_en,
                                   w_lo_ext, w_hi_ext, AW);
  assign w_stride_full = next_addr(w_addr_ext, w_stride_ext, i_ring_en,
                                   w_lo_ext, w_hi_ext, AW);

  assign w_step_addr   = w_step_full[AW-1:0];
  assign w_stride_addr = w_stride_full[AW-1:0];
  // Bits above AW are zero by construction; folding them in keeps every bit
  // of the result in use and would flag any residue as a wrap.
  assign w_step_wrap   = w_step_full[MAXW]   | (|w_step_full[MAXW-1:AW]);
  assign w_stride_wrap = w_stride_full[MAXW] | (|w_stride_full[MAXW-1:AW]);

  // A zero length request still produces one beat
  logic [LW-1:0] w_beats_init;
  assign w_beats_init = (i_burst_len == '0) ? LW'(1) : i_burst_len;

  // Main FSM, address register and beat counter
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_addr    <= '0;
      r_beats   <= '0;
      r_done    <= 1'b0;
      r_wrapped <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_wrapped <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_clr) begin
            r_addr <= '0;
          end else if (i_burst_start) begin
            r_addr  <= i_burst_base;
            r_beats <= w_beats_init;
            r_state <= ST_BURST;
          end else if (i_step_en) begin
            r_addr    <= w_step_addr;
            r_wrapped <= w_step_wrap;
          end else if (w_load_any) begin
            r_addr <= w_load_data;
          end
        end

        ST_BURST: begin
          if (i_clr) begin
            r_addr  <= '0;
            r_beats <= '0;
            r_state <= ST_IDLE;
          end else if (i_addr_ready) begin
            // o_addr_valid is high throughout BURST, so ready alone
            // completes the handshake.
            if (r_beats <= LW'(1)) begin
              // Last beat: keep its address on o_addr after the burst.
              r_beats <= '0;
              r_done  <= 1'b1;
              r_state <= ST_IDLE;
            end else begin
              r_beats   <= r_beats - LW'(1);
              r_addr    <= w_stride_addr;
              r_wrapped <= w_stride_wrap;
            end
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_addr       = r_addr;
  assign o_addr_valid = (r_state == ST_BURST);
  assign o_busy       = (r_state == ST_BURST);
  assign o_done       = r_done;
  assign o_wrapped    = r_wrapped;
  assign o_dbg_state  = r_state;

endmodule
